// File: rtl/bin_stream_tx.sv
// ---------------------------------------------------------------------------
// bin_stream_tx : ping-pong frame buffer that replays FFT bins as a tagged stream
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bin_stream_tx #(
   parameter int D_BW     = 14,
   parameter int N_BINS   = 513,
   parameter int N_FRAMES = 64,
   parameter int GAP      = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [9:0]             wr_addr,
   input  logic signed [D_BW-1:0] wr_data,
   input  logic                   wr_commit,
   output logic                   wr_ready,
   output logic signed [D_BW-1:0] data_o,
   output logic                   do_en,
   output logic [9:0]             group_idx,
   output logic [6:0]             group_num,
   output logic                   is_first,
   output logic                   is_last,
   output logic                   ovf_err
);

   localparam logic [9:0]      c_LAST_BIN   = 10'(N_BINS - 1);
   localparam logic [6:0]      c_LAST_FRAME = 7'(N_FRAMES - 1);
   localparam int              c_GW         = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [c_GW-1:0] c_GAP_LAST   = c_GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_GAP    = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [1:0]        r_full, w_full_nxt;
   logic              r_fill, r_rd;
   logic [9:0]        r_addr, w_addr_nxt;
   logic [c_GW-1:0]   r_gap, w_gap_nxt;
   logic [6:0]        r_frame;
   logic              w_issue, w_last_addr, w_commit_ok, w_wr_ok;
   logic [9:0]        w_rd_addr;

   logic signed [D_BW-1:0] r_mem [0:1][0:N_BINS-1];
   logic signed [D_BW-1:0] r_ram_q;

   logic              r_s1_vld, r_s1_first, r_s1_last;
   logic [9:0]        r_s1_idx;
   logic [6:0]        r_s1_num;

   assign wr_ready    = ~r_full[r_fill];
   assign w_commit_ok = wr_commit & wr_ready;
   assign w_wr_ok     = wr_en & wr_ready & (wr_addr <= c_LAST_BIN);

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_gap_nxt   = r_gap;
      w_issue     = 1'b0;
      w_rd_addr   = r_addr;
      w_full_nxt  = r_full;
      case (r_state)
         S_IDLE: begin
            if (r_full[r_rd]) begin
               w_issue     = 1'b1;
               w_rd_addr   = '0;
               w_addr_nxt  = 10'd1;
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            w_issue    = 1'b1;
            w_addr_nxt = r_addr + 10'd1;
         end
         S_GAP: begin
            if (r_gap == c_GAP_LAST) begin
               w_addr_nxt  = '0;
               w_state_nxt = r_full[r_rd] ? S_STREAM : S_IDLE;
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // End of frame overrides whatever the state decided above.
      w_last_addr = w_issue & (w_rd_addr == c_LAST_BIN);
      if (w_last_addr) begin
         w_addr_nxt = '0;
         if (GAP > 0) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = '0;
         end else if (r_full[~r_rd]) begin
            w_state_nxt = S_STREAM;
         end else begin
            w_state_nxt = S_IDLE;
         end
         w_full_nxt[r_rd] = 1'b0;
      end
      if (w_commit_ok) begin
         w_full_nxt[r_fill] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_fill][wr_addr] <= wr_data;
      end
      if (w_issue) begin
         r_ram_q <= r_mem[r_rd][w_rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_full     <= '0;
         r_fill     <= 1'b0;
         r_rd       <= 1'b0;
         r_addr     <= '0;
         r_gap      <= '0;
         r_frame    <= '0;
         r_s1_vld   <= 1'b0;
         r_s1_idx   <= '0;
         r_s1_num   <= '0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
         do_en      <= 1'b0;
         data_o     <= '0;
         group_idx  <= '0;
         group_num  <= '0;
         is_first   <= 1'b0;
         is_last    <= 1'b0;
         ovf_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_full  <= w_full_nxt;
         r_fill  <= r_fill ^ w_commit_ok;
         r_rd    <= r_rd ^ w_last_addr;
         r_addr  <= w_addr_nxt;
         r_gap   <= w_gap_nxt;
         if (w_last_addr) begin
            r_frame <= (r_frame == c_LAST_FRAME) ? 7'd0 : r_frame + 7'd1;
         end
         ovf_err <= ovf_err | ((wr_en | wr_commit) & ~wr_ready);

         // Tags travel alongside the RAM read so they line up with its data.
         r_s1_vld   <= w_issue;
         r_s1_idx   <= w_issue ? w_rd_addr : 10'd0;
         r_s1_num   <= r_frame;
         r_s1_first <= w_issue & (r_frame == 7'd0) & (w_rd_addr == 10'd0);
         r_s1_last  <= w_last_addr & (r_frame == c_LAST_FRAME);

         do_en     <= r_s1_vld;
         data_o    <= r_s1_vld ? r_ram_q : '0;
         group_idx <= r_s1_idx;
         is_first  <= r_s1_first;
         is_last   <= r_s1_last;
         if (r_s1_vld) begin
            group_num <= r_s1_num;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bin_stream_tx.sv
// Directed bench for bin_stream_tx: one GAP=0 instance and one GAP=3 instance on shared inputs.
`default_nettype none

module tb_bin_stream_tx;

   localparam int D_BW = 14;
   localparam int NB   = 513;
   localparam int NF   = 64;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   wr_en = 1'b0;
   logic [9:0]             wr_addr = '0;
   logic signed [D_BW-1:0] wr_data = '0;
   logic                   wr_commit = 1'b0;

   logic                   wr_ready, do_en, is_first, is_last, ovf_err;
   logic signed [D_BW-1:0] data_o;
   logic [9:0]             group_idx;
   logic [6:0]             group_num;

   logic                   wr_ready3, do_en3, is_first3, is_last3, ovf_err3;
   logic signed [D_BW-1:0] data_o3;
   logic [9:0]             group_idx3;
   logic [6:0]             group_num3;

   bin_stream_tx #(.D_BW(D_BW), .N_BINS(NB), .N_FRAMES(NF), .GAP(0)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_commit(wr_commit), .wr_ready(wr_ready), .data_o(data_o), .do_en(do_en),
      .group_idx(group_idx), .group_num(group_num), .is_first(is_first),
      .is_last(is_last), .ovf_err(ovf_err));

   bin_stream_tx #(.D_BW(D_BW), .N_BINS(NB), .N_FRAMES(NF), .GAP(3)) dut3 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_commit(wr_commit), .wr_ready(wr_ready3), .data_o(data_o3), .do_en(do_en3),
      .group_idx(group_idx3), .group_num(group_num3), .is_first(is_first3),
      .is_last(is_last3), .ovf_err(ovf_err3));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Odd frames are scrambled so a bank mix-up shows in the data.
   function automatic logic [D_BW-1:0] pat(input int s, input int a);
      logic [D_BW-1:0] v;
      v = D_BW'(a);
      return ((s % 2) == 1) ? (v ^ 14'h2A5A) : v;
   endfunction

   int m_bin = 0, m_frame = 0, m_seq = 0, m_beats = 0, m_idle = 0;
   int m_nfirst = 0, m_nlast = 0;
   int m_gap_at [128];
   int m3_idle = 0, m3_gap = -1;
   bit m3_seen = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         m_bin = 0; m_frame = 0; m_seq = 0; m_beats = 0; m_idle = 0;
         m_nfirst = 0; m_nlast = 0;
         foreach (m_gap_at[i]) m_gap_at[i] = -1;
         m3_idle = 0; m3_gap = -1; m3_seen = 1'b0;
      end else begin
         if (do_en) begin
            check("group_idx", 32'(group_idx), 32'(m_bin));
            check("data_o", {18'd0, data_o}, {18'd0, pat(m_seq, m_bin)});
            check("group_num", 32'(group_num), 32'(m_frame));
            check("is_first", 32'(is_first), 32'(m_frame == 0 && m_bin == 0));
            check("is_last", 32'(is_last), 32'(m_frame == NF - 1 && m_bin == NB - 1));
            m_beats++;
            if (m_bin == 0 && m_seq < 128) m_gap_at[m_seq] = m_idle;
            if (is_first) m_nfirst++;
            if (is_last) begin
               m_nlast++;
               check("utt_beats", 32'(m_beats), 32'(NB * NF));
            end
            m_idle = 0;
            m_bin++;
            if (m_bin == NB) begin
               m_bin   = 0;
               m_seq++;
               m_frame = (m_frame + 1) % NF;
            end
         end else begin
            check("idle_outputs", {7'd0, data_o, group_idx, is_first, is_last}, 32'd0);
            check("mid_frame_bubble", 32'(m_bin), 32'd0);
            m_idle++;
         end
         if (do_en3) begin
            if (group_idx3 == 10'd0 && m3_seen) m3_gap = m3_idle;
            m3_seen = 1'b1;
            m3_idle = 0;
         end else begin
            m3_idle++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      wr_en     = 1'b0;
      wr_commit = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic fill(input int s, input int n);
      for (int a = 0; a < n; a++) begin
         wr_en   = 1'b1;
         wr_addr = 10'(a);
         wr_data = pat(s, a);
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic commit();
      wr_commit = 1'b1;
      tick();
      wr_commit = 1'b0;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!wr_ready && t < 3000) begin
         tick();
         t++;
      end
      check("wr_ready_wait", 32'(wr_ready), 32'd1);
   endtask

   task automatic wait_seq(input int n, input int budget);
      int t = 0;
      while (m_seq < n && t < budget) begin
         tick();
         t++;
      end
      check("frames_done", 32'(m_seq), 32'(n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state and first frame latency
      do_reset();
      @(negedge clk);
      check("rst_do_en", 32'(do_en), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_ovf", 32'(ovf_err), 32'd0);
      check("rst_group_num", 32'(group_num), 32'd0);
      check("rst_outputs", {7'd0, data_o, group_idx, is_first, is_last}, 32'd0);
      tick();
      fill(0, NB);
      commit();
      @(negedge clk);
      check("lat_cyc0", 32'(do_en), 32'd0);
      @(negedge clk);
      check("lat_cyc1", 32'(do_en), 32'd0);
      @(negedge clk);
      check("lat_cyc2", 32'(do_en), 32'd1);
      check("first_idx", 32'(group_idx), 32'd0);
      check("first_flag", 32'(is_first), 32'd1);
      wait_seq(1, 1000);

      // Two queued frames, second committed before the first ends
      fill(1, NB);
      commit();
      fill(2, 500);
      commit();
      @(negedge clk);
      check("ready_both_full", 32'(wr_ready), 32'd0);

      // Write and commit while both banks are full
      tick();
      wr_en     = 1'b1;
      wr_addr   = 10'd510;
      wr_data   = 14'h1234;
      wr_commit = 1'b1;
      tick();
      wr_en     = 1'b0;
      wr_commit = 1'b0;
      @(negedge clk);
      check("ovf_set", 32'(ovf_err), 32'd1);
      wait_seq(3, 2000);
      check("zero_bubble", 32'(m_gap_at[2]), 32'd0);
      repeat (20) tick();
      check("no_extra_frame", 32'(m_seq), 32'd3);
      check("ovf_sticky", 32'(ovf_err), 32'd1);

      // Full utterance and wrap into the next one
      for (int s = 3; s <= NF; s++) begin
         wait_ready();
         fill(s, NB);
         commit();
      end
      wait_seq(NF + 1, 3000);
      check("is_first_count", 32'(m_nfirst), 32'd2);
      check("is_last_count", 32'(m_nlast), 32'd1);
      check("ovf_still_set", 32'(ovf_err), 32'd1);

      // Inter-frame gap on the GAP=3 instance
      do_reset();
      fill(0, NB);
      commit();
      fill(1, 500);
      commit();
      wait_seq(2, 2000);
      repeat (10) tick();
      check("gap3_idle", 32'(m3_gap), 32'd3);
      check("gap0_idle", 32'(m_gap_at[1]), 32'd0);

      // Reset in the middle of a frame
      fill(2, NB);
      commit();
      begin
         int t = 0;
         while (!(do_en && group_idx == 10'd200) && t < 2000) begin
            tick();
            t++;
         end
      end
      check("reached_bin200", 32'(group_idx), 32'd200);
      check("pre_rst_group_num", 32'(group_num), 32'd2);
      rst = 1'b1;
      tick();
      check("mid_rst_do_en", 32'(do_en), 32'd0);
      check("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
      check("mid_rst_group_num", 32'(group_num), 32'd0);
      check("mid_rst_outputs", {7'd0, data_o, group_idx, is_first, is_last}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_rst_quiet", 32'(do_en), 32'd0);
      end
      fill(0, NB);
      commit();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("restart_do_en", 32'(do_en), 32'd1);
      check("restart_idx", 32'(group_idx), 32'd0);
      check("restart_num", 32'(group_num), 32'd0);
      check("restart_first", 32'(is_first), 32'd1);
      wait_seq(1, 1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
